// File: rtl/mini_src_io_pkg.sv
// Shared definitions for the mini_src IO controllers: default word width and
// the request/acknowledge handshake state encoding.
package mini_src_io_pkg;

    localparam int IO_DATA_W = 32;

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_SEND    = 2'd1,
        S_RELEASE = 2'd2
    } io_state_t;

endpackage

// File: rtl/out_port_ctrl_fifo.sv
// Small synchronous FIFO for output-port words. It has an occupancy count,
// full/empty flags and a combinational head. Only control state is reset.
module out_fifo #(
    parameter  int DATA_W = 32,
    parameter  int DEPTH  = 4,
    localparam int CNT_W  = $clog2(DEPTH) + 1,
    localparam int PTR_W  = $clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              clr,
    input  logic              push,
    input  logic [DATA_W-1:0] push_data,
    input  logic              pop,
    output logic [DATA_W-1:0] head,
    output logic [CNT_W-1:0]  count,
    output logic              full,
    output logic              empty
);

    logic [DATA_W-1:0] mem [DEPTH];
    logic [PTR_W-1:0]  wr_ptr;
    logic [PTR_W-1:0]  rd_ptr;
    logic              push_ok;
    logic              pop_ok;

    assign full    = (count == CNT_W'(DEPTH));
    assign empty   = (count == '0);
    assign push_ok = push && !full;
    assign pop_ok  = pop && !empty;
    assign head    = mem[rd_ptr];

    // Storage is not reset: contents are meaningless once the count is zero.
    always_ff @(posedge clk) begin
        if (push_ok) begin
            mem[wr_ptr] <= push_data;
        end
    end

    // Pointer width equals log2(DEPTH), so increments wrap modulo DEPTH.
    always_ff @(posedge clk or negedge clr) begin
        if (!clr) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push_ok) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop_ok) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({push_ok, pop_ok})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/out_port_ctrl.sv
// Output-port controller. Buffered "out" words are presented on a registered
// port using a 4-phase valid/ack handshake with the external device.
module out_port_ctrl
    import mini_src_io_pkg::*;
#(
    parameter  int DATA_W = IO_DATA_W,
    parameter  int DEPTH  = 4,
    localparam int CNT_W  = $clog2(DEPTH) + 1
) (
    input  logic              clk,
    input  logic              clr,
    input  logic              wr_en,
    input  logic [DATA_W-1:0] wr_data,
    output logic              stall,
    output logic              overflow,
    output logic [CNT_W-1:0]  fifo_count,
    output logic              busy,
    output logic [DATA_W-1:0] ext_data,
    output logic              ext_valid,
    input  logic              ext_ack
);

    io_state_t         state_q;
    io_state_t         state_d;
    logic              pop;
    logic              fifo_full;
    logic              fifo_empty;
    logic [DATA_W-1:0] fifo_head;

    out_fifo #(
        .DATA_W (DATA_W),
        .DEPTH  (DEPTH)
    ) u_fifo (
        .clk       (clk),
        .clr       (clr),
        .push      (wr_en),
        .push_data (wr_data),
        .pop       (pop),
        .head      (fifo_head),
        .count     (fifo_count),
        .full      (fifo_full),
        .empty     (fifo_empty)
    );

    assign stall = fifo_full;
    assign busy  = (state_q != S_IDLE) || !fifo_empty;

    always_ff @(posedge clk or negedge clr) begin
        if (!clr) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // A new word launches only once the device has released ack, so a stale
    // ack left high from the previous transfer cannot be mistaken for a new one.
    always_comb begin
        state_d = state_q;
        pop     = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (!fifo_empty && !ext_ack) begin
                    pop     = 1'b1;
                    state_d = S_SEND;
                end
            end
            S_SEND: begin
                if (ext_ack) begin
                    state_d = S_RELEASE;
                end
            end
            S_RELEASE: begin
                if (!ext_ack) begin
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // The port register behaves like a latch-on-send output: it holds the last word.
    always_ff @(posedge clk or negedge clr) begin
        if (!clr) begin
            ext_data  <= '0;
            ext_valid <= 1'b0;
            overflow  <= 1'b0;
        end else begin
            if (pop) begin
                ext_data  <= fifo_head;
                ext_valid <= 1'b1;
            end else if (state_q == S_SEND && ext_ack) begin
                ext_valid <= 1'b0;
            end
            if (wr_en && fifo_full) begin
                overflow <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_out_port_ctrl.sv
// Directed bench for out_port_ctrl. A scoreboard queue holds the words the
// device should receive; a monitor compares each new ext_valid request.
module tb_out_port_ctrl;

    localparam int DATA_W = 32;
    localparam int DEPTH  = 4;
    localparam int CNT_W  = $clog2(DEPTH) + 1;

    logic              clk = 1'b0;
    logic              clr = 1'b0;
    logic              wr_en = 1'b0;
    logic [DATA_W-1:0] wr_data = '0;
    logic              stall;
    logic              overflow;
    logic [CNT_W-1:0]  fifo_count;
    logic              busy;
    logic [DATA_W-1:0] ext_data;
    logic              ext_valid;
    logic              ext_ack = 1'b0;

    int n_vec = 0;
    int n_err = 0;
    logic [DATA_W-1:0] exp_q [$];
    logic prev_v = 1'b0;

    out_port_ctrl #(
        .DATA_W (DATA_W),
        .DEPTH  (DEPTH)
    ) dut (
        .clk        (clk),
        .clr        (clr),
        .wr_en      (wr_en),
        .wr_data    (wr_data),
        .stall      (stall),
        .overflow   (overflow),
        .fifo_count (fifo_count),
        .busy       (busy),
        .ext_data   (ext_data),
        .ext_valid  (ext_valid),
        .ext_ack    (ext_ack)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h, want %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(negedge clk);
    endtask

    task automatic drive_wr(input logic [31:0] d);
        wr_en   = 1'b1;
        wr_data = d;
        tick();
        wr_en   = 1'b0;
    endtask

    task automatic push(input logic [31:0] d);
        exp_q.push_back(d);
        drive_wr(d);
    endtask

    task automatic do_reset();
        tick();
        wr_en   = 1'b0;
        ext_ack = 1'b0;
        clr     = 1'b0;
        exp_q.delete();
        tick();
        tick();
        clr = 1'b1;
        tick();
    endtask

    task automatic wait_valid(input string name);
        int n = 0;
        while (!ext_valid && n < 50) begin
            tick();
            n++;
        end
        check({name, "_valid_timeout"}, 32'(ext_valid), 32'd1);
    endtask

    task automatic ack_one(input string name);
        wait_valid(name);
        ext_ack = 1'b1;
        tick();
        check({name, "_valid_drop"}, 32'(ext_valid), 32'd0);
        ext_ack = 1'b0;
        tick();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout, want completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        fork
            forever begin
                @(negedge clk);
                if (clr && ext_valid && !prev_v) begin
                    if (exp_q.size() == 0) begin
                        check("spurious_valid_qsize", 32'(exp_q.size()), 32'd1);
                    end else begin
                        check("deliver_word", ext_data, exp_q.pop_front());
                    end
                end
                prev_v = ext_valid;
            end
        join_none

        // Reset state
        do_reset();
        check("rst_valid", 32'(ext_valid), 32'd0);
        check("rst_data", ext_data, 32'd0);
        check("rst_count", 32'(fifo_count), 32'd0);
        check("rst_stall", 32'(stall), 32'd0);
        check("rst_overflow", 32'(overflow), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);

        // Single word, latency and hold after ack
        push(32'hDEADBEEF);
        check("t2_count_k", 32'(fifo_count), 32'd1);
        check("t2_no_bypass", 32'(ext_valid), 32'd0);
        tick();
        check("t2_valid_k1", 32'(ext_valid), 32'd1);
        check("t2_data_k1", ext_data, 32'hDEADBEEF);
        check("t2_busy", 32'(busy), 32'd1);
        ext_ack = 1'b1;
        tick();
        check("t2_valid_acked", 32'(ext_valid), 32'd0);
        check("t2_data_held", ext_data, 32'hDEADBEEF);
        ext_ack = 1'b0;
        tick();
        check("t2_idle_busy", 32'(busy), 32'd0);

        // Fill while the device holds a previous word, then overflow
        do_reset();
        push(32'h11);
        tick();
        push(32'h1);
        push(32'h2);
        push(32'h3);
        check("t3_count3", 32'(fifo_count), 32'd3);
        check("t3_stall0", 32'(stall), 32'd0);
        push(32'h4);
        check("t3_count4", 32'(fifo_count), 32'd4);
        check("t3_stall1", 32'(stall), 32'd1);
        drive_wr(32'h5);
        check("t3_overflow", 32'(overflow), 32'd1);
        check("t3_count_after_ovf", 32'(fifo_count), 32'd4);
        for (int i = 0; i < 5; i++) ack_one("t3_drain");
        repeat (3) tick();
        check("t3_empty", 32'(fifo_count), 32'd0);
        check("t3_busy_end", 32'(busy), 32'd0);
        check("t3_overflow_sticky", 32'(overflow), 32'd1);

        // Push and pop on the same edge
        do_reset();
        ext_ack = 1'b1;
        push(32'hB0);
        push(32'hB1);
        check("t4_blocked_valid", 32'(ext_valid), 32'd0);
        check("t4_count2", 32'(fifo_count), 32'd2);
        ext_ack = 1'b0;
        push(32'hB2);
        check("t4_pushpop_count", 32'(fifo_count), 32'd2);
        check("t4_data_b0", ext_data, 32'hB0);
        push(32'hB3);
        push(32'hB4);
        check("t4_full", 32'(stall), 32'd1);
        ext_ack = 1'b1;
        tick();
        ext_ack = 1'b0;
        tick();
        check("t4_no_ovf_yet", 32'(overflow), 32'd0);
        check("t4_count_full", 32'(fifo_count), 32'd4);
        drive_wr(32'hB5);
        check("t4_refused_ovf", 32'(overflow), 32'd1);
        check("t4_count3", 32'(fifo_count), 32'd3);
        check("t4_data_b1", ext_data, 32'hB1);
        for (int i = 0; i < 4; i++) ack_one("t4_drain");
        repeat (3) tick();
        check("t4_busy_end", 32'(busy), 32'd0);

        // Stale ack held through RELEASE
        do_reset();
        push(32'hC0);
        push(32'hC1);
        push(32'hC2);
        check("t5_valid", 32'(ext_valid), 32'd1);
        check("t5_count2", 32'(fifo_count), 32'd2);
        ext_ack = 1'b1;
        tick();
        for (int i = 0; i < 3; i++) begin
            tick();
            check("t5_stale_valid", 32'(ext_valid), 32'd0);
            check("t5_stale_count", 32'(fifo_count), 32'd2);
        end
        ext_ack = 1'b0;
        tick();
        check("t5_release_valid", 32'(ext_valid), 32'd0);
        tick();
        check("t5_next_valid", 32'(ext_valid), 32'd1);
        check("t5_next_data", ext_data, 32'hC1);
        ack_one("t5_c1");
        ack_one("t5_c2");

        // Reset mid-SEND with three words queued
        do_reset();
        push(32'hE0);
        push(32'hE1);
        push(32'hE2);
        push(32'hE3);
        check("t1_valid_before", 32'(ext_valid), 32'd1);
        check("t1_count3", 32'(fifo_count), 32'd3);
        #2;
        clr = 1'b0;
        exp_q.delete();
        #1;
        check("t1_async_valid", 32'(ext_valid), 32'd0);
        check("t1_async_data", ext_data, 32'd0);
        check("t1_async_count", 32'(fifo_count), 32'd0);
        check("t1_async_busy", 32'(busy), 32'd0);
        tick();
        tick();
        clr = 1'b1;
        for (int i = 0; i < 6; i++) begin
            tick();
            check("t1_no_resend", 32'(ext_valid), 32'd0);
        end

        // Stream with random ack delays and pointer wrap
        do_reset();
        fork
            begin
                for (int i = 0; i < 10; i++) begin
                    int n = 0;
                    while (stall && n < 100) begin
                        tick();
                        n++;
                    end
                    push(32'hA0 + 32'(i));
                end
            end
            begin
                for (int j = 0; j < 10; j++) begin
                    wait_valid("t6");
                    repeat ($urandom_range(0, 5)) tick();
                    ext_ack = 1'b1;
                    tick();
                    ext_ack = 1'b0;
                    repeat ($urandom_range(0, 2)) tick();
                end
            end
        join
        repeat (6) tick();
        check("t6_overflow", 32'(overflow), 32'd0);
        check("t6_busy", 32'(busy), 32'd0);
        check("t6_all_delivered", 32'(exp_q.size()), 32'd0);
        check("t6_count", 32'(fifo_count), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
